mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the core's instruction-fetch (IF) requester and load/store (D) requester.
- Sits between the fetch/LSU stages and the unified memory, in place of separate InstMemory/DataMemory ports.
- Accepts up to one request per cycle and tracks in-flight reads with a tag pipeline.
- Routes each response back to its owner exactly MEM_LAT cycles after acceptance.

Parameters:
- ADDR_W, 32: byte-address width.
- DATA_W, 32: data width; fixed at 32 (4 byte lanes).
- MEM_LAT, 1: fixed SRAM read latency in cycles; legal range 1..4.
- STARVE_MAX, 4: consecutive denied IF cycles before IF is forced to win.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- if_req_valid, in, 1: fetch request.
- if_req_ready, out, 1: fetch request accepted this cycle.
- if_req_addr, in, ADDR_W: fetch byte address.
- if_rsp_valid, out, 1: fetch data valid.
- if_rsp_rdata, out, DATA_W: fetch data.
- d_req_valid, in, 1: data request.
- d_req_ready, out, 1: data request accepted this cycle.
- d_req_we, in, 1: 1 = store.
- d_req_be, in, 4: store byte enables.
- d_req_addr, in, ADDR_W: data byte address.
- d_req_wdata, in, DATA_W: store data.
- d_rsp_valid, out, 1: load data or store completion.
- d_rsp_rdata, out, DATA_W: load data; 0 for stores.
- mem_en, out, 1: SRAM access strobe.
- mem_we, out, 4: SRAM byte write enables.
- mem_addr, out, ADDR_W-2: SRAM word address.
- mem_wdata, out, DATA_W: SRAM write data.
- mem_rdata, in, DATA_W: SRAM read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset values: all ready, rsp_valid, mem_en and mem_we outputs are 0; rdata outputs are 0. Tag pipeline cleared, starvation counter = 0, FSM = NORMAL.
- Handshake: a request is accepted when valid && ready in the same cycle. Ready is combinational from valid and FSM state. A requester holds valid and payload stable until accepted. No response backpressure: requesters must consume rsp_valid when it is asserted.
- Grant rule:
  - Only one valid: that one is granted.
  - Both valid in NORMAL: D wins.
  - Both valid in FORCE_I: IF wins.
  - Neither valid: mem_en = 0.
- FSM:
  - NORMAL -> FORCE_I when the starvation counter reaches STARVE_MAX.
  - FORCE_I -> NORMAL on the next IF acceptance.
- Starvation counter:
  - Increments each cycle if_req_valid && !if_req_ready.
  - Clears on any IF acceptance or when if_req_valid = 0.
  - Saturates at STARVE_MAX.
- Memory drive (combinational from the granted request):
  - mem_addr = addr[ADDR_W-1:2]; the low 2 address bits are ignored.
  - mem_we = d_req_be if the granted request is a D store, else 0.
- Tag pipeline: MEM_LAT-deep shift register holding {valid, owner, is_store}, loaded on each acceptance.
  - At the output stage, the owner's rsp_valid = 1 for exactly one cycle.
  - rdata = mem_rdata for loads/fetches; d_rsp_rdata = 0 for stores.
  - Back-to-back acceptances produce back-to-back responses in acceptance order.
- Latency: response cycle = acceptance cycle + MEM_LAT. Throughput is 1 request per cycle.
- Simultaneous events: the non-granted requester sees ready = 0 and retries automatically next cycle.
- Reset mid-operation: in-flight tags are dropped and no response is issued for them. Outputs return to reset values on the cycle after rst is sampled high.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds output perf_conflict_cnt (32 bits, reset 0). It increments each cycle both req_valid are high, wrapping at 2^32.
- Not defined: the port and counter are absent.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef owner_e {OWN_IF, OWN_D};
  - typedef arb_state_e {NORMAL, FORCE_I};
  - packed struct tag_t {valid, owner, is_store};
  - constant BE_W = 4.
- One natural sub-module: mem_arb_tag_pipe, the MEM_LAT-deep tag shift register with synchronous clear.

Test Plan:
- IF only, addr 0xFFFF_0000, MEM_LAT=1 -> mem_addr=0x3FFF_C000; if_rsp_valid one cycle later with mem_rdata=0x0000_0013.
- D store addr 0x0000_0104, be=4'b0011, wdata=0xDEAD_BEEF -> mem_we=4'b0011, mem_addr=0x41; d_rsp_valid after 1 cycle with rdata=0.
- Both valid continuously, STARVE_MAX=4 -> D granted cycles 0-3, IF granted cycle 4, D again cycle 5.
- MEM_LAT=3, alternating IF/D acceptances on 4 consecutive cycles -> 4 responses on cycles 3-6, each routed to the correct owner in order.
- rst asserted 1 cycle after an accepted load with MEM_LAT=2 -> no d_rsp_valid ever issued for that load; all outputs 0.
- MEM_ARB_PERF_EN defined, 7 cycles both valid -> perf_conflict_cnt=7.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
//   owner_e     : which requester a memory access belongs to
//   arb_state_e : arbitration mode (data priority, or fetch forced to win)
//   tag_t       : per-access bookkeeping carried alongside the SRAM read
//   BE_W        : number of byte lanes on the 32-bit data path
package mem_arb_pkg;

  localparam int BE_W = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_I = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   is_store;
  } tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// MEM_LAT-deep shift register of access tags, aligned with the SRAM read
// latency so the output stage describes the access whose data is on
// mem_rdata in the current cycle.
// Ports:
//   clk, rst : clock, synchronous active-high clear of every stage
//   tag_in   : tag of the access issued this cycle (valid=0 when idle)
//   tag_out  : tag of the access issued MEM_LAT cycles ago
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [MEM_LAT-1:0] stage_reg;

  generate
    for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) stage_reg[gi] <= '0;
          else     stage_reg[gi] <= tag_in;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) stage_reg[gi] <= '0;
          else     stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tag_out = stage_reg[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the instruction-fetch
// requester (IF) and the load/store requester (D). At most one request is
// accepted per cycle; D wins conflicts unless IF has been denied STARVE_MAX
// cycles in a row, in which case IF wins the next conflict. Each response is
// returned to its owner exactly MEM_LAT cycles after acceptance.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req_valid/ready/addr          : fetch request handshake + byte address
//   if_rsp_valid/rdata               : fetch response
//   d_req_valid/ready/we/be/addr/wdata : load/store request
//   d_rsp_valid/rdata                : load data or store completion (rdata 0)
//   mem_en/we/addr/wdata, mem_rdata  : SRAM interface (word addressed)
// Optional build macro MEM_ARB_PERF_EN adds perf_conflict_cnt, a free-running
// count of cycles in which both requesters were valid.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [BE_W-1:0]   d_req_be,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,output logic [31:0]      perf_conflict_cnt
`endif
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       state_reg, state_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             grant_if, grant_d;
  tag_t             tag_in, tag_out;

  // Byte-offset bits never reach the word-addressed SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[1:0], d_req_addr[1:0]};

  // Grants are blocked while rst is high so nothing is accepted that the
  // clearing tag pipeline would then lose.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (!rst) begin
      grant_if = if_req_valid && (!d_req_valid || state_reg == FORCE_I);
      grant_d  = d_req_valid && !grant_if;
    end
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  // The mode switch looks at the next counter value so that IF wins in the
  // cycle immediately after its STARVE_MAX-th consecutive denial.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!if_req_valid || grant_if)
      starve_cnt_next = '0;
    else if (starve_cnt_reg < CNT_MAX)
      starve_cnt_next = starve_cnt_reg + 1'b1;

    state_next = state_reg;
    case (state_reg)
      NORMAL:  if (starve_cnt_next == CNT_MAX) state_next = FORCE_I;
      FORCE_I: if (grant_if)                   state_next = NORMAL;
      default:                                 state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= NORMAL;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign mem_en    = grant_if || grant_d;
  assign mem_addr  = grant_d ? d_req_addr[ADDR_W-1:2] : if_req_addr[ADDR_W-1:2];
  assign mem_we    = (grant_d && d_req_we) ? d_req_be : '0;
  assign mem_wdata = d_req_wdata;

  always_comb begin
    tag_in          = '0;
    tag_in.valid    = mem_en;
    tag_in.owner    = grant_d ? OWN_D : OWN_IF;
    tag_in.is_store = grant_d && d_req_we;
  end

  mem_arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Response data is gated so idle and store-completion cycles present 0.
  assign if_rsp_valid = tag_out.valid && (tag_out.owner == OWN_IF);
  assign d_rsp_valid  = tag_out.valid && (tag_out.owner == OWN_D);
  assign if_rsp_rdata = if_rsp_valid ? mem_rdata : '0;
  assign d_rsp_rdata  = (d_rsp_valid && !tag_out.is_store) ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      perf_cnt_reg <= '0;
    else if (if_req_valid && d_req_valid)
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
  end

  assign perf_conflict_cnt = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM (latency LAT).
// Each request step states the grant it must receive; accepted requests push
// their expected response into a queue that a negedge monitor pops when due.
module tb_mem_port_arbiter;

  localparam int LAT = 3;
  localparam int SM  = 4;

  logic        clk;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [3:0]  d_req_be;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_be(d_req_be), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,.perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return 32'h0000_0013 + (32'(i) << 12);
  endfunction

  // Behavioural SRAM: 256 words, byte writes, read data LAT cycles after en.
  logic [31:0] sram    [0:255];
  logic [31:0] rd_pipe [0:LAT-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= mem_en ? sram[mem_addr[7:0]] : 32'h0BAD_0BAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  typedef struct {
    int          due;
    bit          own_d;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [0:255];
  int          checks   = 0;
  int          failures = 0;
  int          conf_cnt = 0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_if_valid", 32'(if_rsp_valid), 32'(!e.own_d));
        chk("rsp_d_valid", 32'(d_rsp_valid), 32'(e.own_d));
        if (e.own_d) chk("rsp_d_rdata", d_rsp_rdata, e.data);
        else         chk("rsp_if_rdata", if_rsp_rdata, e.data);
        $display("rsp cyc=%0d owner=%s data=%h", cyc, e.own_d ? "D" : "IF", e.data);
      end else begin
        chk("rsp_if_idle", 32'(if_rsp_valid), 32'd0);
        chk("rsp_d_idle", 32'(d_rsp_valid), 32'd0);
      end
    end
  end

  // eg: expected grant, 0 = none, 1 = IF, 2 = D.
  task automatic step(input logic iv, input logic [31:0] ia, input logic dv, input logic dwe,
                      input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                      input int eg, input string nm);
    exp_t e;
    if_req_valid = iv; if_req_addr = ia;
    d_req_valid = dv; d_req_we = dwe; d_req_be = be; d_req_addr = da; d_req_wdata = wd;
    if (iv && dv) conf_cnt++;
    #2;
    chk({nm, ":if_ready"}, 32'(if_req_ready), 32'(eg == 1));
    chk({nm, ":d_ready"}, 32'(d_req_ready), 32'(eg == 2));
    chk({nm, ":mem_en"}, 32'(mem_en), 32'(eg != 0));
    if (eg == 1) begin
      chk({nm, ":mem_addr"}, {2'b00, mem_addr}, {2'b00, ia[31:2]});
      chk({nm, ":mem_we"}, 32'(mem_we), 32'd0);
      e.due = cyc + LAT; e.own_d = 1'b0; e.data = ref_mem[ia[9:2]];
      q.push_back(e);
    end else if (eg == 2) begin
      chk({nm, ":mem_addr"}, {2'b00, mem_addr}, {2'b00, da[31:2]});
      chk({nm, ":mem_we"}, 32'(mem_we), dwe ? 32'(be) : 32'd0);
      e.due = cyc + LAT; e.own_d = 1'b1;
      if (dwe) begin
        chk({nm, ":mem_wdata"}, mem_wdata, wd);
        e.data = 32'd0;
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[da[9:2]][8*b +: 8] = wd[8*b +: 8];
      end else begin
        e.data = ref_mem[da[9:2]];
      end
      q.push_back(e);
    end
    $display("req cyc=%0d %s iv=%0d ia=%h dv=%0d we=%0d da=%h grant_exp=%0d", cyc, nm, iv, ia, dv, dwe, da, eg);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 0, 0, 0, "idle");
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, ":if_ready"}, 32'(if_req_ready), 32'd0);
    chk({nm, ":d_ready"}, 32'(d_req_ready), 32'd0);
    chk({nm, ":mem_en"}, 32'(mem_en), 32'd0);
    chk({nm, ":mem_we"}, 32'(mem_we), 32'd0);
    chk({nm, ":if_rsp_valid"}, 32'(if_rsp_valid), 32'd0);
    chk({nm, ":d_rsp_valid"}, 32'(d_rsp_valid), 32'd0);
    chk({nm, ":if_rsp_rdata"}, if_rsp_rdata, 32'd0);
    chk({nm, ":d_rsp_rdata"}, d_rsp_rdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 0; if_req_addr = 0;
    d_req_valid = 0; d_req_we = 0; d_req_be = 0; d_req_addr = 0; d_req_wdata = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset state, with both requesters asserting valid to prove gating.
    repeat (LAT + 1) @(posedge clk);
    #1;
    if_req_valid = 1; d_req_valid = 1;
    #1;
    check_quiet("reset");
`ifdef MEM_ARB_PERF_EN
    chk("reset:perf", perf_conflict_cnt, 32'd0);
`endif
    rst = 0; if_req_valid = 0; d_req_valid = 0;
    conf_cnt = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Single requesters; low address bits ignored; byte-enable merge.
    step(1, 32'hFFFF_0000, 0, 0, 4'h0, 0, 0, 1, "if_only");
    idle(1);
    step(0, 0, 1, 1, 4'b0011, 32'h0000_0104, 32'hDEAD_BEEF, 2, "d_store");
    step(0, 0, 1, 0, 4'h0, 32'h0000_0107, 0, 2, "d_load_merge");
    step(1, 32'h0000_0003, 0, 0, 4'h0, 0, 0, 1, "if_low_bits");
    idle(LAT + 1);

    // Alternating IF/D acceptances on consecutive cycles.
    step(1, 32'h0000_0040, 0, 0, 4'h0, 0, 0, 1, "alt_if0");
    step(0, 0, 1, 1, 4'b1100, 32'h0000_0044, 32'h1234_5678, 2, "alt_d_st");
    step(1, 32'h0000_0048, 0, 0, 4'h0, 0, 0, 1, "alt_if1");
    step(0, 0, 1, 0, 4'h0, 32'h0000_0044, 0, 2, "alt_d_ld");
    idle(LAT + 1);

    // Forced mode persists while IF is idle, until IF is accepted.
    step(1, 32'h0000_0050, 1, 0, 4'h0, 32'h0000_0060, 0, 2, "fs_c0");
    step(1, 32'h0000_0050, 1, 0, 4'h0, 32'h0000_0064, 0, 2, "fs_c1");
    step(1, 32'h0000_0050, 1, 0, 4'h0, 32'h0000_0068, 0, 2, "fs_c2");
    step(1, 32'h0000_0050, 1, 0, 4'h0, 32'h0000_006C, 0, 2, "fs_c3");
    step(0, 0, 1, 0, 4'h0, 32'h0000_0070, 0, 2, "fs_d_alone");
    step(1, 32'h0000_0050, 1, 0, 4'h0, 32'h0000_0074, 0, 1, "fs_if_wins");
    step(1, 32'h0000_0054, 1, 0, 4'h0, 32'h0000_0074, 0, 2, "fs_normal");
    step(1, 32'h0000_0054, 0, 0, 4'h0, 0, 0, 1, "fs_if_drain");
    idle(LAT + 1);

    // Reset one cycle after an accepted load: its response must never appear.
    step(0, 0, 1, 0, 4'h0, 32'h0000_0104, 0, 2, "pre_rst_load");
    rst = 1; if_req_valid = 1; d_req_valid = 1;
    q.delete();
    #2;
    chk("rst_cycle:if_ready", 32'(if_req_ready), 32'd0);
    chk("rst_cycle:d_ready", 32'(d_req_ready), 32'd0);
    chk("rst_cycle:mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    if_req_valid = 0; d_req_valid = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    #1;
    check_quiet("after_rst");
    rst = 0;
    conf_cnt = 0;
    @(posedge clk); #1;
    idle(LAT + 2);

    // Continuous conflict: D, D, D, D, IF, D, D, then drain IF.
    step(1, 32'h0000_0010, 1, 0, 4'h0, 32'h0000_0020, 0, 2, "sv_c0");
    step(1, 32'h0000_0010, 1, 0, 4'h0, 32'h0000_0024, 0, 2, "sv_c1");
    step(1, 32'h0000_0010, 1, 0, 4'h0, 32'h0000_0028, 0, 2, "sv_c2");
    step(1, 32'h0000_0010, 1, 0, 4'h0, 32'h0000_002C, 0, 2, "sv_c3");
    step(1, 32'h0000_0010, 1, 0, 4'h0, 32'h0000_0030, 0, 1, "sv_c4_if");
    step(1, 32'h0000_0014, 1, 0, 4'h0, 32'h0000_0030, 0, 2, "sv_c5");
    step(1, 32'h0000_0014, 1, 0, 4'h0, 32'h0000_0034, 0, 2, "sv_c6");
    step(1, 32'h0000_0014, 0, 0, 4'h0, 0, 0, 1, "sv_drain");
    idle(LAT + 2);

`ifdef MEM_ARB_PERF_EN
    chk("perf_conflict_cnt", perf_conflict_cnt, 32'(conf_cnt));
`endif
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
